// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, execution codes and
// the stage FSM encoding. The writeback datapath muxes use the same codes.
package mem_stage_pkg;

  localparam int DATA_SIZE = 32;
  localparam int REG_SIZE  = 5;
  localparam int CODE_SIZE = 6;

  localparam logic [CODE_SIZE-1:0] ALU_CODE = 6'd1;
  localparam logic [CODE_SIZE-1:0] LW_CODE  = 6'd2;
  localparam logic [CODE_SIZE-1:0] SW_CODE  = 6'd3;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  function automatic logic is_mem_op(input logic [CODE_SIZE-1:0] code);
    return (code == LW_CODE) || (code == SW_CODE);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side handshake and data-memory bus of the memory stage.
// Handshake: a transfer happens at a rising edge where ex_valid & ex_ready are both 1;
// the offer may change freely while ex_ready=0. mem_req holds with stable
// address/data until the edge at which mem_ack=1 is sampled.
interface mem_stage_ex_if;
  import mem_stage_pkg::*;

  logic                 ex_valid;
  logic                 ex_ready;
  logic [CODE_SIZE-1:0] ex_code;
  logic [DATA_SIZE-1:0] ex_alu_out;
  logic [DATA_SIZE-1:0] ex_k_out;
  logic [REG_SIZE-1:0]  ex_rd;

  modport master (output ex_valid, ex_code, ex_alu_out, ex_k_out, ex_rd, input ex_ready);
  modport slave  (input ex_valid, ex_code, ex_alu_out, ex_k_out, ex_rd, output ex_ready);
endinterface

interface mem_stage_mem_if;
  import mem_stage_pkg::*;

  logic                 mem_req;
  logic                 mem_we;
  logic [DATA_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic                 mem_ack;
  logic [DATA_SIZE-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_stage_mem_wait_timer.sv
// Wait counter for an outstanding memory request. The count is the ordinal of
// the current wait cycle, so limit is high in the MEM_TIMEOUT-th cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic limit
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign limit = (cnt_q == LIMIT_VAL);

  // Clear preloads 1: the cycle after the clear is the first wait cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_W'(1);
    end else if (enable && !limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: performs LW/SW over a req/ack port with timeout abort,
// passes ALU and bubble instructions through, and registers the writeback bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_ex_if.slave        ex,
  mem_stage_mem_if.master      mem,
  output logic                 wb_valid,
  output logic [DATA_SIZE-1:0] a_out,
  output logic [DATA_SIZE-1:0] m_out,
  output logic [CODE_SIZE-1:0] e_code,
  output logic [REG_SIZE-1:0]  wb_rd,
  output logic                 wb_we,
  output logic                 mem_err,
  output state_e               state_dbg
);

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [DATA_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [DATA_SIZE-1:0] a_out_q, a_out_d;
  logic [DATA_SIZE-1:0] m_out_q, m_out_d;
  logic [CODE_SIZE-1:0] e_code_q, e_code_d;
  logic [REG_SIZE-1:0]  wb_rd_q, wb_rd_d;
  logic                 wb_we_q, wb_we_d;
  logic                 mem_err_q, mem_err_d;

  logic timer_clear, timer_enable, timer_limit;

  assign timer_clear  = (state_q == RUN);
  assign timer_enable = (state_q == MEM_WAIT) && !mem.mem_ack;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .limit  (timer_limit)
  );

  assign ex.ex_ready    = (state_q == RUN);
  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign a_out          = a_out_q;
  assign m_out          = m_out_q;
  assign e_code         = e_code_q;
  assign wb_rd          = wb_rd_q;
  assign wb_we          = wb_we_q;
  assign mem_err        = mem_err_q;
  assign state_dbg      = state_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    a_out_d     = a_out_q;
    m_out_d     = m_out_q;
    e_code_d    = e_code_q;
    wb_rd_d     = wb_rd_q;
    wb_we_d     = wb_we_q;
    mem_err_d   = mem_err_q;

    if (state_q == RUN) begin
      if (ex.ex_valid) begin
        a_out_d     = ex.ex_alu_out;
        e_code_d    = ex.ex_code;
        wb_rd_d     = ex.ex_rd;
        mem_addr_d  = ex.ex_alu_out;
        mem_wdata_d = ex.ex_k_out;
        if (is_mem_op(ex.ex_code)) begin
          mem_req_d = 1'b1;
          mem_we_d  = (ex.ex_code == SW_CODE);
          state_d   = MEM_WAIT;
        end else begin
          wb_valid_d = 1'b1;
          wb_we_d    = (ex.ex_code == ALU_CODE) && (ex.ex_rd != '0);
        end
      end
    end else begin
      // An ack in the limit cycle takes priority over the timeout abort.
      if (mem.mem_ack) begin
        mem_req_d  = 1'b0;
        wb_valid_d = 1'b1;
        state_d    = RUN;
        if (e_code_q == LW_CODE) begin
          m_out_d = mem.mem_rdata;
          wb_we_d = (wb_rd_q != '0);
        end else begin
          wb_we_d = 1'b0;
        end
      end else if (timer_limit) begin
        mem_req_d  = 1'b0;
        wb_valid_d = 1'b1;
        wb_we_d    = 1'b0;
        mem_err_d  = 1'b1;
        state_d    = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      a_out_q     <= '0;
      m_out_q     <= '0;
      e_code_q    <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      a_out_q     <= a_out_d;
      m_out_q     <= m_out_d;
      e_code_q    <= e_code_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      mem_err_q   <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized instruction stream
// scored against an instruction-level model of the writeback bundle.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TMO = 4;
  localparam int BW  = 2 * DATA_SIZE + CODE_SIZE + REG_SIZE + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_stage_ex_if  ex_if ();
  mem_stage_mem_if mem_if ();

  logic                 wb_valid;
  logic [DATA_SIZE-1:0] a_out;
  logic [DATA_SIZE-1:0] m_out;
  logic [CODE_SIZE-1:0] e_code;
  logic [REG_SIZE-1:0]  wb_rd;
  logic                 wb_we;
  logic                 mem_err;
  state_e               state_dbg;

  mem_stage #(.MEM_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex        (ex_if),
    .mem       (mem_if),
    .wb_valid  (wb_valid),
    .a_out     (a_out),
    .m_out     (m_out),
    .e_code    (e_code),
    .wb_rd     (wb_rd),
    .wb_we     (wb_we),
    .mem_err   (mem_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [BW-1:0]        exp_q[$];
  logic [DATA_SIZE-1:0] model_m   = '0;
  logic                 model_err = 1'b0;

  logic [BW-1:0] obs;
  assign obs = {a_out, m_out, e_code, wb_rd, wb_we};

  function automatic logic [BW-1:0] mk(input logic [DATA_SIZE-1:0] a, input logic [DATA_SIZE-1:0] m,
                                       input logic [CODE_SIZE-1:0] c, input logic [REG_SIZE-1:0] rd,
                                       input logic we);
    return {a, m, c, rd, we};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_ex(input logic v, input logic [CODE_SIZE-1:0] c, input logic [DATA_SIZE-1:0] a,
                          input logic [DATA_SIZE-1:0] k, input logic [REG_SIZE-1:0] rd);
    ex_if.ex_valid   = v;
    ex_if.ex_code    = c;
    ex_if.ex_alu_out = a;
    ex_if.ex_k_out   = k;
    ex_if.ex_rd      = rd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_ex(1'b0, '0, '0, '0, '0);
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (2) step();
    checks++; if (ex_if.ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ex_ready got=%0b want=1", ex_if.ex_ready); end
    checks++; if (state_dbg !== RUN) begin failures++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, RUN); end
    checks++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_ctl got=%0b%0b want=00", mem_if.mem_req, mem_if.mem_we); end
    checks++; if (mem_if.mem_addr !== '0 || mem_if.mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_bus got=%h/%h want=0/0", mem_if.mem_addr, mem_if.mem_wdata); end
    checks++; if (wb_valid !== 1'b0 || mem_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b want=00", wb_valid, mem_err); end
    checks++; if (obs !== '0) begin failures++; $display("FAIL reset_bundle got=%h want=0", obs); end
    rst = 1'b0;
  endtask

  task automatic test_alu_back_to_back();
    logic [DATA_SIZE-1:0] vals[3];
    logic [REG_SIZE-1:0]  rds[3];
    vals = '{32'h11, 32'h22, 32'h33};
    rds  = '{5'd3, 5'd4, 5'd0};
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, ALU_CODE, vals[i], $urandom, rds[i]);
      checks++; if (ex_if.ex_ready !== 1'b1) begin failures++; $display("FAIL alu_ready[%0d] got=%0b want=1", i, ex_if.ex_ready); end
      step();
      checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_wb_valid[%0d] got=%0b want=1", i, wb_valid); end
      checks++; if (obs !== mk(vals[i], model_m, ALU_CODE, rds[i], rds[i] != 0)) begin failures++; $display("FAIL alu_bundle[%0d] got=%h want=%h", i, obs, mk(vals[i], model_m, ALU_CODE, rds[i], rds[i] != 0)); end
    end
    drive_ex(1'b0, '0, '0, '0, '0);
    step();
    checks++; if (wb_valid !== 1'b0 || a_out !== 32'h33) begin failures++; $display("FAIL alu_idle got=%0b/%h want=0/33", wb_valid, a_out); end
  endtask

  task automatic test_lw();
    drive_ex(1'b1, LW_CODE, 32'h100, $urandom, 5'd5);
    step();
    drive_ex(1'b0, '0, '0, '0, '0);
    for (int c = 1; c <= 3; c++) begin
      checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0 || mem_if.mem_addr !== 32'h100) begin failures++; $display("FAIL lw_req[%0d] got=%0b%0b/%h want=10/100", c, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr); end
      checks++; if (ex_if.ex_ready !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL lw_stall[%0d] got=%0b%0b want=00", c, ex_if.ex_ready, wb_valid); end
      if (c == 3) begin mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF; end
      step();
    end
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = $urandom;
    model_m = 32'hDEADBEEF;
    checks++; if (mem_if.mem_req !== 1'b0 || ex_if.ex_ready !== 1'b1) begin failures++; $display("FAIL lw_release got=%0b%0b want=01", mem_if.mem_req, ex_if.ex_ready); end
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL lw_wb_valid got=%0b want=1", wb_valid); end
    checks++; if (obs !== mk(32'h100, 32'hDEADBEEF, LW_CODE, 5'd5, 1'b1)) begin failures++; $display("FAIL lw_bundle got=%h want=%h", obs, mk(32'h100, 32'hDEADBEEF, LW_CODE, 5'd5, 1'b1)); end
    step();
    checks++; if (wb_valid !== 1'b0 || m_out !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_pulse got=%0b/%h want=0/deadbeef", wb_valid, m_out); end
  endtask

  task automatic test_sw_then_alu();
    drive_ex(1'b1, SW_CODE, 32'h40, 32'hCAFE, 5'd7);
    step();
    drive_ex(1'b1, ALU_CODE, 32'h55, $urandom, 5'd9);
    checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b1 || mem_if.mem_addr !== 32'h40 || mem_if.mem_wdata !== 32'hCAFE) begin failures++; $display("FAIL sw_req got=%0b%0b/%h/%h want=11/40/cafe", mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata); end
    checks++; if (ex_if.ex_ready !== 1'b0) begin failures++; $display("FAIL sw_stall got=%0b want=0", ex_if.ex_ready); end
    mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0;
    checks++; if (mem_if.mem_req !== 1'b0 || ex_if.ex_ready !== 1'b1) begin failures++; $display("FAIL sw_release got=%0b%0b want=01", mem_if.mem_req, ex_if.ex_ready); end
    checks++; if (wb_valid !== 1'b1 || obs !== mk(32'h40, model_m, SW_CODE, 5'd7, 1'b0)) begin failures++; $display("FAIL sw_bundle got=%0b/%h want=1/%h", wb_valid, obs, mk(32'h40, model_m, SW_CODE, 5'd7, 1'b0)); end
    step();
    drive_ex(1'b0, '0, '0, '0, '0);
    checks++; if (wb_valid !== 1'b1 || obs !== mk(32'h55, model_m, ALU_CODE, 5'd9, 1'b1)) begin failures++; $display("FAIL sw_next_alu got=%0b/%h want=1/%h", wb_valid, obs, mk(32'h55, model_m, ALU_CODE, 5'd9, 1'b1)); end
    step();
  endtask

  task automatic test_timeout();
    int n;
    drive_ex(1'b1, LW_CODE, 32'h200, $urandom, 5'd6);
    step();
    drive_ex(1'b0, '0, '0, '0, '0);
    n = 0;
    while (mem_if.mem_req === 1'b1 && n < 20) begin
      n++;
      step();
    end
    model_err = 1'b1;
    checks++; if (n != TMO) begin failures++; $display("FAIL tmo_req_cycles got=%0d want=%0d", n, TMO); end
    checks++; if (wb_valid !== 1'b1 || obs !== mk(32'h200, model_m, LW_CODE, 5'd6, 1'b0)) begin failures++; $display("FAIL tmo_bundle got=%0b/%h want=1/%h", wb_valid, obs, mk(32'h200, model_m, LW_CODE, 5'd6, 1'b0)); end
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%0b want=1", mem_err); end
    drive_ex(1'b1, ALU_CODE, 32'h77, $urandom, 5'd1);
    step();
    drive_ex(1'b0, '0, '0, '0, '0);
    checks++; if (wb_valid !== 1'b1 || mem_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%0b%0b want=11", wb_valid, mem_err); end
    step();
  endtask

  task automatic test_reset_mid_lw();
    drive_ex(1'b1, LW_CODE, 32'h300, $urandom, 5'd8);
    step();
    drive_ex(1'b0, '0, '0, '0, '0);
    step();
    checks++; if (mem_if.mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre_req got=%0b want=1", mem_if.mem_req); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_m = '0;
    model_err = 1'b0;
    checks++; if (mem_if.mem_req !== 1'b0 || ex_if.ex_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got=%0b%0b%0b want=010", mem_if.mem_req, ex_if.ex_ready, wb_valid); end
    checks++; if (obs !== '0 || mem_err !== 1'b0 || mem_if.mem_addr !== '0) begin failures++; $display("FAIL rstmid_vals got=%h/%0b/%h want=0/0/0", obs, mem_err, mem_if.mem_addr); end
    mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b0 || mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0b%0b want=00", wb_valid, mem_if.mem_req); end
  endtask

  task automatic test_random();
    logic [CODE_SIZE-1:0] code;
    logic [DATA_SIZE-1:0] a, k, rdata;
    logic [REG_SIZE-1:0]  rd;
    logic                 is_mem;
    int                   d;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       code = ALU_CODE;
        1:       code = LW_CODE;
        2:       code = SW_CODE;
        3:       code = '0;
        default: code = CODE_SIZE'($urandom_range(4, 63));
      endcase
      a = $urandom; k = $urandom; rd = REG_SIZE'($urandom_range(0, 31));
      d = $urandom_range(1, TMO + 2);
      rdata = $urandom;
      is_mem = (code == LW_CODE) || (code == SW_CODE);

      // Reference: what writeback must see once this instruction retires.
      if (code == ALU_CODE) begin
        exp_q.push_back(mk(a, model_m, code, rd, rd != 0));
      end else if (!is_mem) begin
        exp_q.push_back(mk(a, model_m, code, rd, 1'b0));
      end else if (d > TMO) begin
        model_err = 1'b1;
        exp_q.push_back(mk(a, model_m, code, rd, 1'b0));
      end else if (code == LW_CODE) begin
        model_m = rdata;
        exp_q.push_back(mk(a, model_m, code, rd, rd != 0));
      end else begin
        exp_q.push_back(mk(a, model_m, code, rd, 1'b0));
      end

      drive_ex(1'b1, code, a, k, rd);
      if (!is_mem) begin
        mem_if.mem_ack   = 1'($urandom_range(0, 1));
        mem_if.mem_rdata = $urandom;
      end
      checks++; if (ex_if.ex_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready[%0d] got=%0b want=1", i, ex_if.ex_ready); end
      step();
      drive_ex(1'b0, '0, '0, '0, '0);
      mem_if.mem_ack = 1'b0;

      if (is_mem) begin
        for (int c = 1; c <= TMO; c++) begin
          checks++;
          if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== a || mem_if.mem_we !== (code == SW_CODE) ||
              (code == SW_CODE && mem_if.mem_wdata !== k)) begin
            failures++;
            $display("FAIL rnd_mem[%0d.%0d] got=%0b%0b/%h/%h want=1%0b/%h/%h", i, c, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, code == SW_CODE, a, k);
          end
          if (c == d) begin mem_if.mem_ack = 1'b1; mem_if.mem_rdata = rdata; end
          step();
          mem_if.mem_ack = 1'b0;
          if (c == d) break;
        end
      end

      begin
        logic [BW-1:0] exp_b;
        exp_b = exp_q.pop_front();
        checks++; if (wb_valid !== 1'b1 || obs !== exp_b) begin failures++; $display("FAIL rnd_wb[%0d] got=%0b/%h want=1/%h", i, wb_valid, obs, exp_b); end
        checks++; if (mem_err !== model_err) begin failures++; $display("FAIL rnd_err[%0d] got=%0b want=%0b", i, mem_err, model_err); end
      end

      if ($urandom_range(0, 1) == 1) begin
        step();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rnd_idle[%0d] got=%0b want=0", i, wb_valid); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu_back_to_back();
    test_lw();
    test_sw_then_alu();
    test_timeout();
    test_reset_mid_lw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
